// File: rtl/scoreboard_pkg.sv
// Shared definitions for the scoreboard clear path: FSM encoding, the system
// clock rate and default timing constants (also used by the hold detector).
package scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_CLEAR        = 2'd1,
        ST_CONFIRM      = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    localparam int CLK_HZ = 50_000_000;

    // Confirmation phase lasts half a second, LED toggles every 1/8 second.
    localparam int DEFAULT_CONFIRM_CYCLES = CLK_HZ / 2;
    localparam int DEFAULT_BLINK_HALF     = CLK_HZ / 8;

    // Register-index width; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scoreboard_clear_sequencer_if.sv
// Valid/ready clear-request channel between the sequencer and the scoreboard
// register file.
interface scoreboard_clear_sequencer_if #(
    parameter int NUM_REGS = 4
);
    import scoreboard_pkg::*;

    localparam int AW = addr_width(NUM_REGS);

    logic          clr_valid;
    logic [AW-1:0] clr_addr;
    logic          clr_ready;

    modport master (output clr_valid, output clr_addr, input clr_ready);
    modport slave  (input clr_valid, input clr_addr, output clr_ready);

endinterface

// File: rtl/scoreboard_clear_sequencer_blink_gen.sv
// Square-wave generator for the confirmation LED. The output starts high on
// the first enabled cycle, toggles every BLINK_HALF enabled cycles and is held
// low while disabled.
module blink_gen #(
    parameter int BLINK_HALF = 6_250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic blink
);

    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt_reg;
    logic          blink_reg;
    logic          enable_d_reg;

    // Restart high on enable rise, then count and toggle until disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
            enable_d_reg  <= 1'b0;
        end else begin
            enable_d_reg <= enable;
            if (enable && !enable_d_reg) begin
                blink_reg     <= 1'b1;
                blink_cnt_reg <= '0;
            end else if (enable) begin
                if (blink_cnt_reg == BLINK_LAST) begin
                    blink_reg     <= ~blink_reg;
                    blink_cnt_reg <= '0;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + BW'(1);
                end
            end else begin
                blink_reg     <= 1'b0;
                blink_cnt_reg <= '0;
            end
        end
    end

    assign blink = blink_reg;

endmodule

// File: rtl/scoreboard_clear_sequencer.sv
// Clears the scoreboard's score registers one by one after a long button
// hold, blinks a confirmation LED, and re-arms only once the button has been
// seen released.
module scoreboard_clear_sequencer
    import scoreboard_pkg::*;
#(
    parameter int NUM_REGS       = 4,
    parameter int CONFIRM_CYCLES = DEFAULT_CONFIRM_CYCLES,
    parameter int BLINK_HALF     = DEFAULT_BLINK_HALF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hold_ready,
    scoreboard_clear_sequencer_if.master clr,
    output logic                         busy,
    output logic                         confirm_led,
    output logic                         done_pulse
);

    localparam int AW = addr_width(NUM_REGS);
    localparam int CW = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);
    localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_CYCLES - 1);

    state_t        state_reg;
    logic          armed_reg;
    logic          clr_valid_reg;
    logic [AW-1:0] clr_addr_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [CW-1:0] confirm_cnt_reg;

    logic clr_xfer;
    logic blink_en;

    assign clr_xfer = clr_valid_reg && clr.clr_ready;

    // High on every edge whose next state is CONFIRM, so the LED register
    // becomes 1 in the same cycle the FSM enters CONFIRM and 0 as it leaves.
    assign blink_en = ((state_reg == ST_CLEAR) && clr_xfer && (clr_addr_reg == LAST_ADDR)) ||
                      ((state_reg == ST_CONFIRM) && (confirm_cnt_reg != CONF_LAST));

    // Main sequencer: arming, clear handshake, confirmation timing, release wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            armed_reg       <= 1'b0;
            clr_valid_reg   <= 1'b0;
            clr_addr_reg    <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            confirm_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            // A low level re-arms; entry to CLEAR (which needs a high level)
            // is the only place armed is dropped, so the two never collide.
            if (!hold_ready) begin
                armed_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (armed_reg && hold_ready) begin
                        state_reg     <= ST_CLEAR;
                        armed_reg     <= 1'b0;
                        clr_valid_reg <= 1'b1;
                        clr_addr_reg  <= '0;
                        busy_reg      <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // hold_ready is deliberately ignored: a started clear finishes.
                    if (clr_xfer) begin
                        if (clr_addr_reg == LAST_ADDR) begin
                            clr_valid_reg   <= 1'b0;
                            clr_addr_reg    <= '0;
                            done_reg        <= 1'b1;
                            confirm_cnt_reg <= '0;
                            state_reg       <= ST_CONFIRM;
                        end else begin
                            clr_addr_reg <= clr_addr_reg + AW'(1);
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (confirm_cnt_reg == CONF_LAST) begin
                        confirm_cnt_reg <= '0;
                        busy_reg        <= 1'b0;
                        state_reg       <= hold_ready ? ST_WAIT_RELEASE : ST_IDLE;
                    end else begin
                        confirm_cnt_reg <= confirm_cnt_reg + CW'(1);
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (!hold_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    clr_valid_reg   <= 1'b0;
                    clr_addr_reg    <= '0;
                    busy_reg        <= 1'b0;
                    confirm_cnt_reg <= '0;
                end
            endcase
        end
    end

    blink_gen #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blink_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (blink_en),
        .blink  (confirm_led)
    );

    assign clr.clr_valid = clr_valid_reg;
    assign clr.clr_addr  = clr_addr_reg;
    assign busy          = busy_reg;
    assign done_pulse    = done_reg;

endmodule

// File: tb/tb_scoreboard_clear_sequencer.sv
// Directed bench for scoreboard_clear_sequencer with an address scoreboard:
// expected clear addresses are queued on each press and popped on every
// observed handshake transfer.
module tb_scoreboard_clear_sequencer;
    import scoreboard_pkg::*;

    localparam int NUM_REGS       = 4;
    localparam int CONFIRM_CYCLES = 8;
    localparam int BLINK_HALF     = 2;
    localparam int AW             = addr_width(NUM_REGS);

    logic clk = 1'b0;
    logic rst;
    logic hold_ready;
    logic busy;
    logic confirm_led;
    logic done_pulse;

    scoreboard_clear_sequencer_if #(.NUM_REGS(NUM_REGS)) sif ();

    scoreboard_clear_sequencer #(
        .NUM_REGS       (NUM_REGS),
        .CONFIRM_CYCLES (CONFIRM_CYCLES),
        .BLINK_HALF     (BLINK_HALF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hold_ready  (hold_ready),
        .clr         (sif),
        .busy        (busy),
        .confirm_led (confirm_led),
        .done_pulse  (done_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int n_done   = 0;
    logic [AW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_sequence();
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_q.push_back(AW'(i));
        end
    endtask

    // Advance one clock; score any transfer and check done_pulse / stall hold.
    task automatic step();
        logic          exp_done;
        logic          was_stall;
        logic [AW-1:0] prev_addr;
        logic [AW-1:0] exp_addr;
        exp_done  = 1'b0;
        was_stall = !rst && sif.clr_valid && !sif.clr_ready;
        prev_addr = sif.clr_addr;
        if (!rst && sif.clr_valid && sif.clr_ready) begin
            n_xfer++;
            chk("xfer_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_addr = exp_q.pop_front();
                chk("xfer_addr", 32'(sif.clr_addr), 32'(exp_addr));
                exp_done = (exp_addr == AW'(NUM_REGS - 1));
            end
        end
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done_pulse), 32'(exp_done));
        if (done_pulse) n_done++;
        if (was_stall) begin
            chk("stall_valid", 32'(sif.clr_valid), 1);
            chk("stall_addr", 32'(sif.clr_addr), 32'(prev_addr));
        end
        $display("t=%0t rst=%0b hold=%0b valid=%0b ready=%0b addr=%0d busy=%0b led=%0b done=%0b",
                 $time, rst, hold_ready, sif.clr_valid, sif.clr_ready, sif.clr_addr,
                 busy, confirm_led, done_pulse);
    endtask

    task automatic run_to_idle();
        int guard;
        guard = 0;
        while ((busy || sif.clr_valid) && guard < 100) begin
            step();
            guard++;
        end
        chk("idle_reached", 32'(busy), 0);
        chk("queue_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(sif.clr_valid), 0);
        chk({tag, "_addr"}, 32'(sif.clr_addr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_led"}, 32'(confirm_led), 0);
        chk({tag, "_done"}, 32'(done_pulse), 0);
    endtask

    initial begin
        logic [7:0] led_pat;
        int base_x;
        int base_d;
        int cyc;
        logic stalled;
        led_pat = 8'b0011_0011;

        // Reset with the button already held.
        rst = 1'b1;
        hold_ready = 1'b1;
        sif.clr_ready = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        // Held through reset: must not trigger until seen released.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("no_arm_valid", 32'(sif.clr_valid), 0);
        end
        hold_ready = 1'b0;
        step();
        hold_ready = 1'b1;
        push_sequence();
        step();
        chk("arm_valid", 32'(sif.clr_valid), 1);
        chk("arm_addr", 32'(sif.clr_addr), 0);
        chk("arm_busy", 32'(busy), 1);
        hold_ready = 1'b0;
        step();
        step();
        sif.clr_ready = 1'b1;
        run_to_idle();

        // Back-to-back transfers and blink pattern.
        base_d = n_done;
        hold_ready = 1'b1;
        push_sequence();
        step();
        hold_ready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            chk("b2b_valid", 32'(sif.clr_valid), 1);
            chk("b2b_addr", 32'(sif.clr_addr), 32'(i));
            step();
        end
        chk("b2b_valid_low", 32'(sif.clr_valid), 0);
        for (int i = 0; i < CONFIRM_CYCLES; i++) begin
            chk("led_pattern", 32'(confirm_led), 32'(led_pat[i]));
            chk("confirm_busy", 32'(busy), 1);
            step();
        end
        chk("led_after", 32'(confirm_led), 0);
        chk("busy_after", 32'(busy), 0);
        chk("done_once", 32'(n_done - base_d), 1);

        // Backpressure: alternate ready plus a 5-cycle stall at addr 2.
        base_x = n_xfer;
        base_d = n_done;
        sif.clr_ready = 1'b0;
        hold_ready = 1'b1;
        push_sequence();
        step();
        hold_ready = 1'b0;
        cyc = 0;
        stalled = 1'b0;
        while (n_done == base_d && cyc < 80) begin
            if (!stalled && sif.clr_valid && sif.clr_addr == AW'(2)) begin
                stalled = 1'b1;
                sif.clr_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    chk("bp_hold_valid", 32'(sif.clr_valid), 1);
                    chk("bp_hold_addr", 32'(sif.clr_addr), 2);
                    step();
                end
            end
            sif.clr_ready = (cyc % 2 == 1);
            step();
            cyc++;
        end
        chk("bp_done", 32'(n_done - base_d), 1);
        chk("bp_xfers", 32'(n_xfer - base_x), 4);
        sif.clr_ready = 1'b1;
        run_to_idle();

        // Hold kept past CONFIRM: wait for release, no retrigger.
        hold_ready = 1'b1;
        push_sequence();
        step();
        for (int i = 0; i < NUM_REGS + CONFIRM_CYCLES; i++) step();
        chk("wr_busy", 32'(busy), 0);
        chk("wr_led", 32'(confirm_led), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("wr_no_valid", 32'(sif.clr_valid), 0);
        end
        hold_ready = 1'b0;
        step();
        hold_ready = 1'b1;
        push_sequence();
        step();
        chk("repress_valid", 32'(sif.clr_valid), 1);
        chk("repress_addr", 32'(sif.clr_addr), 0);
        hold_ready = 1'b0;
        run_to_idle();

        // Reset mid-clear at addr 2.
        hold_ready = 1'b1;
        push_sequence();
        step();
        hold_ready = 1'b0;
        step();
        step();
        chk("pre_rst_valid", 32'(sif.clr_valid), 1);
        chk("pre_rst_addr", 32'(sif.clr_addr), 2);
        rst = 1'b1;
        sif.clr_ready = 1'b0;
        hold_ready = 1'b1;
        exp_q.delete();
        step();
        check_all_zero("mid_rst");
        rst = 1'b0;
        sif.clr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_no_valid", 32'(sif.clr_valid), 0);
        end
        hold_ready = 1'b0;
        step();
        hold_ready = 1'b1;
        push_sequence();
        step();
        chk("post_rst_valid", 32'(sif.clr_valid), 1);
        chk("post_rst_addr", 32'(sif.clr_addr), 0);
        hold_ready = 1'b0;
        run_to_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
